// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store sequencer holding MAR/MDR
// stable for a fixed number of wait cycles, with an I/O window decode.
//
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   ADDR_IN, DATA_IN effective address and store data, latched on accept
//   REQ, WE          request and direction, sampled only while idle
//   DATA_OUT         registered read data, held until the next read
//   DONE, BUSY       completion pulse, not-idle indicator
//   MEM_ADDR         MAR to memory and I/O
//   MEM_WDATA        MDR to the shared data bus
//   MEM_RDATA        read data from the memory / I/O mux
//   MEM_CE_N         memory chip enable (active low)
//   MEM_OE_N         read strobe (active low)
//   MEM_WE_N         write strobe (active low)
//   IO_SEL           I/O window select
//   WDATA_EN         bus drive enable for MEM_WDATA
module mem_access_unit #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_BASE     = 16'hFE00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR_IN,
    input  logic [15:0] DATA_IN,
    input  logic        REQ,
    input  logic        WE,
    output logic [15:0] DATA_OUT,
    output logic        DONE,
    output logic        BUSY,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    output logic        MEM_CE_N,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic        IO_SEL,
    output logic        WDATA_EN
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] mar_q,   mar_d;
    logic [15:0] mdr_q,   mdr_d;
    logic        op_we_q, op_we_d;
    logic [15:0] dout_q,  dout_d;

    logic        io_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        op_we_d = op_we_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (REQ) begin
                    mar_d   = ADDR_IN;
                    mdr_d   = DATA_IN;
                    op_we_d = WE;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Counter reaching zero marks the last wait cycle;
                // read data is sampled on that same edge.
                if (cnt_q == 4'd0) begin
                    state_d = COMPLETE;
                    if (!op_we_q) begin
                        dout_d = MEM_RDATA;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mar_q   <= 16'd0;
            mdr_q   <= 16'd0;
            op_we_q <= 1'b0;
            dout_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            op_we_q <= op_we_d;
            dout_q  <= dout_d;
        end
    end

    assign io_hit = (mar_q >= IO_BASE);

    always_comb begin
        MEM_CE_N = 1'b1;
        MEM_OE_N = 1'b1;
        MEM_WE_N = 1'b1;
        IO_SEL   = 1'b0;
        WDATA_EN = 1'b0;
        if (state_q == ACCESS) begin
            MEM_CE_N = io_hit;
            IO_SEL   = io_hit;
            MEM_OE_N = op_we_q;
            MEM_WE_N = !op_we_q;
            WDATA_EN = op_we_q;
        end
    end

    assign DONE      = (state_q == COMPLETE);
    assign BUSY      = (state_q != IDLE);
    assign MEM_ADDR  = mar_q;
    assign MEM_WDATA = mdr_q;
    assign DATA_OUT  = dout_q;

endmodule
